// File: rtl/dth_sensor_responder_pkg.sv
// rtl/dth_sensor_responder_pkg.sv - shared DTH link widths, default timing, states and checksum helper
package dth_sensor_responder_pkg;

    localparam int FRAME_W = 40;
    localparam int TIMER_W = 21;
    localparam int IDX_W   = 6;

    // Default phase lengths in 100 MHz cycles; the host end uses the same numbers.
    localparam int START_MIN_CYC_DEF = 1_000_000;
    localparam int RESP_DLY_CYC_DEF  = 3_000;
    localparam int ACK_LOW_CYC_DEF   = 8_000;
    localparam int ACK_HIGH_CYC_DEF  = 8_000;
    localparam int BIT_LOW_CYC_DEF   = 5_000;
    localparam int BIT0_HIGH_CYC_DEF = 2_700;
    localparam int BIT1_HIGH_CYC_DEF = 7_000;
    localparam int GUARD_CYC_DEF     = 4;

    // One-hot responder states.
    typedef enum logic [8:0] {
        S_IDLE      = 9'b0_0000_0001,
        S_START_LOW = 9'b0_0000_0010,
        S_RESP_DLY  = 9'b0_0000_0100,
        S_ACK_LOW   = 9'b0_0000_1000,
        S_ACK_HIGH  = 9'b0_0001_0000,
        S_BIT_LOW   = 9'b0_0010_0000,
        S_BIT_HIGH  = 9'b0_0100_0000,
        S_END_LOW   = 9'b0_1000_0000,
        S_WAIT_HIGH = 9'b1_0000_0000
    } state_t;

    // 8-bit wrapping sum of the four data bytes, optionally inverted for error injection.
    function automatic logic [7:0] dth_checksum(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d,
        input logic       inv
    );
        logic [7:0] sum;
        sum = a + b + c + d;
        return inv ? ~sum : sum;
    endfunction

endpackage

// File: rtl/dth_sync.sv
// rtl/dth_sync.sv - two-flop synchronizer for the DTH line, resets to the idle-high level
module dth_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; reset to 1 so an idle pulled-up bus is not mistaken for a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dth_sensor_responder.sv
// rtl/dth_sensor_responder.sv - sensor-side DTH responder: start detect, ACK, 40-bit frame, contention watch
module dth_sensor_responder
    import dth_sensor_responder_pkg::*;
#(
    parameter int START_MIN_CYC = START_MIN_CYC_DEF,
    parameter int RESP_DLY_CYC  = RESP_DLY_CYC_DEF,
    parameter int ACK_LOW_CYC   = ACK_LOW_CYC_DEF,
    parameter int ACK_HIGH_CYC  = ACK_HIGH_CYC_DEF,
    parameter int BIT_LOW_CYC   = BIT_LOW_CYC_DEF,
    parameter int BIT0_HIGH_CYC = BIT0_HIGH_CYC_DEF,
    parameter int BIT1_HIGH_CYC = BIT1_HIGH_CYC_DEF,
    parameter int GUARD_CYC     = GUARD_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        DTH,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       corrupt_chk,
    output logic       busy,
    output logic       frame_done,
    output logic       bus_err
);

    // Phase-end compare values: a phase of N cycles ends when the timer reads N-1.
    localparam logic [TIMER_W-1:0] L_START_MIN = TIMER_W'(START_MIN_CYC);
    localparam logic [TIMER_W-1:0] L_RESP_END  = TIMER_W'(RESP_DLY_CYC - 1);
    localparam logic [TIMER_W-1:0] L_ACKL_END  = TIMER_W'(ACK_LOW_CYC - 1);
    localparam logic [TIMER_W-1:0] L_ACKH_END  = TIMER_W'(ACK_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] L_BITL_END  = TIMER_W'(BIT_LOW_CYC - 1);
    localparam logic [TIMER_W-1:0] L_B0_END    = TIMER_W'(BIT0_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] L_B1_END    = TIMER_W'(BIT1_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] L_GUARD     = TIMER_W'(GUARD_CYC);
    localparam logic [IDX_W-1:0]   L_LAST_IDX  = IDX_W'(FRAME_W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [IDX_W-1:0]     r_idx;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_frame_done;
    logic                 r_bus_err;

    logic                 w_dq_s;
    logic                 w_dq_oe;
    logic                 w_busy;
    logic                 w_latch;
    logic                 w_bit_adv;
    logic                 w_watch;
    logic                 w_frame_done_nxt;
    logic                 w_bus_err_nxt;
    logic [TIMER_W-1:0]   w_bit_end;

    dth_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (DTH),
        .o_q (w_dq_s)
    );

    // Open drain: pull low or let the external pull-up win.
    assign DTH        = w_dq_oe ? 1'b0 : 1'bz;
    assign busy       = w_busy;
    assign frame_done = r_frame_done;
    assign bus_err    = r_bus_err;

    // The frame is shifted out MSB first, so the current bit is always the top one.
    assign w_bit_end  = r_frame[FRAME_W-1] ? L_B1_END : L_B0_END;

    // State, phase timer, bit index, frame shift register and event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_bus_err    <= w_bus_err_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_timer != {TIMER_W{1'b1}}) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_latch) begin
                r_frame <= {hum_int, hum_dec, tmp_int, tmp_dec,
                            dth_checksum(hum_int, hum_dec, tmp_int, tmp_dec, corrupt_chk)};
                r_idx   <= '0;
            end else if (w_bit_adv) begin
                r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    // Next-state, line drive and busy decode; contention overrides any released phase.
    always_comb begin
        w_state_nxt      = r_state;
        w_dq_oe          = 1'b0;
        w_busy           = 1'b0;
        w_latch          = 1'b0;
        w_bit_adv        = 1'b0;
        w_watch          = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_bus_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_dq_s) w_state_nxt = S_START_LOW;
            end
            S_START_LOW: begin
                if (w_dq_s) begin
                    if (r_timer >= L_START_MIN) begin
                        w_state_nxt = S_RESP_DLY;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RESP_DLY: begin
                w_busy  = 1'b1;
                w_watch = 1'b1;
                if (r_timer == L_RESP_END) w_state_nxt = S_ACK_LOW;
            end
            S_ACK_LOW: begin
                w_busy  = 1'b1;
                w_dq_oe = 1'b1;
                if (r_timer == L_ACKL_END) w_state_nxt = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                w_busy  = 1'b1;
                w_watch = 1'b1;
                if (r_timer == L_ACKH_END) w_state_nxt = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                w_busy  = 1'b1;
                w_dq_oe = 1'b1;
                if (r_timer == L_BITL_END) w_state_nxt = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                w_busy  = 1'b1;
                w_watch = 1'b1;
                if (r_timer == w_bit_end) begin
                    w_bit_adv   = 1'b1;
                    w_state_nxt = (r_idx == L_LAST_IDX) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                w_busy  = 1'b1;
                w_dq_oe = 1'b1;
                if (r_timer == L_BITL_END) begin
                    w_state_nxt      = S_IDLE;
                    w_frame_done_nxt = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (w_dq_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // The guard window hides our own release still travelling through the synchronizer.
        if (w_watch && (r_timer >= L_GUARD) && !w_dq_s) begin
            w_state_nxt   = S_WAIT_HIGH;
            w_bus_err_nxt = 1'b1;
            w_bit_adv     = 1'b0;
        end
    end

endmodule

// File: tb/tb_dth_sensor_responder.sv
// tb/tb_dth_sensor_responder.sv - scoreboard bench: host model on a pulled-up DTH line, line-level frame decoder
`timescale 1ns/1ps
module tb_dth_sensor_responder;

    localparam int START_MIN = 200;
    localparam int RESP      = 30;
    localparam int ACKL      = 80;
    localparam int ACKH      = 80;
    localparam int BITL      = 50;
    localparam int B0H       = 27;
    localparam int B1H       = 70;
    localparam int GUARD     = 4;

    localparam logic [39:0] F_1 = 40'h37_00_19_00_50;
    localparam logic [39:0] F_C = 40'h37_00_19_00_AF;
    localparam logic [39:0] F_6 = 40'h55_00_19_00_6E;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hum_int = 8'h37;
    logic [7:0] hum_dec = 8'h00;
    logic [7:0] tmp_int = 8'h19;
    logic [7:0] tmp_dec = 8'h00;
    logic       corrupt_chk = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       bus_err;
    wire        DTH;

    pullup (DTH);
    assign DTH = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dth_sensor_responder #(
        .START_MIN_CYC (START_MIN),
        .RESP_DLY_CYC  (RESP),
        .ACK_LOW_CYC   (ACKL),
        .ACK_HIGH_CYC  (ACKH),
        .BIT_LOW_CYC   (BITL),
        .BIT0_HIGH_CYC (B0H),
        .BIT1_HIGH_CYC (B1H),
        .GUARD_CYC     (GUARD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DTH         (DTH),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .tmp_int     (tmp_int),
        .tmp_dec     (tmp_dec),
        .corrupt_chk (corrupt_chk),
        .busy        (busy),
        .frame_done  (frame_done),
        .bus_err     (bus_err)
    );

    typedef struct packed {
        logic        is_err;
        logic [39:0] frame;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int   lows[0:63];
    int   highs[0:63];
    int   n_low = 0;
    int   low_len = 0;
    int   high_len = 0;
    int   drive_cnt = 0;
    logic prev_sl = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: measures sensor-driven low runs and released gaps, checks events against the scoreboard.
    always @(negedge clk) begin
        logic        sl;
        logic        ok;
        logic [39:0] dec;
        exp_t        e;
        sl = (DTH === 1'b0) && !host_low;
        if (busy && !prev_busy) begin
            n_low    = 0;
            high_len = 0;
            low_len  = 0;
        end
        if (sl) begin
            if (!prev_sl) begin
                if (n_low < 64) highs[n_low] = high_len;
                low_len = 0;
            end
            low_len++;
            drive_cnt++;
        end else begin
            if (prev_sl) begin
                if (n_low < 64) lows[n_low] = low_len;
                n_low++;
                high_len = 0;
            end
            high_len++;
        end
        prev_sl   = sl;
        prev_busy = busy;

        if (frame_done === 1'b1 || bus_err === 1'b1) begin
            check("done_err_exclusive", {63'd0, frame_done & bus_err}, 64'd0);
            check("event_expected", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("event_kind", {63'd0, bus_err}, {63'd0, e.is_err});
                if (frame_done === 1'b1 && !e.is_err) begin
                    ok = 1'b1;
                    for (int i = 0; i < 40; i++) begin
                        dec[39-i] = (highs[i+2] > (B0H + B1H) / 2);
                        if (highs[i+2] != (dec[39-i] ? B1H : B0H)) ok = 1'b0;
                        if (lows[i+1] != BITL) ok = 1'b0;
                    end
                    check("frame_bits", {24'd0, dec}, {24'd0, e.frame});
                    check("low_runs", n_low, 42);
                    check("resp_gap", highs[0], RESP);
                    check("ack_low", lows[0], ACKL);
                    check("ack_high", highs[1], ACKH);
                    check("end_low", lows[41], BITL);
                    check("bit_timing", {63'd0, ok}, 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_start(input int low_cyc);
        tick();
        host_low = 1'b1;
        repeat (low_cyc) tick();
        host_low = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
        repeat (20) tick();
    endtask

    task automatic wait_busy(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(name, {63'd0, busy}, 64'd1);
        repeat (2) tick();
    endtask

    task automatic wait_nlow(input string name, input int target, input int limit);
        int n = 0;
        while (n_low < target && n < limit) begin
            tick();
            n++;
        end
        check(name, {63'd0, n_low >= target}, 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        logic seen;
        int   n;

        // Reset state
        repeat (5) tick();
        check("rst_dth", {63'd0, DTH}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_bus_err", {63'd0, bus_err}, 64'd0);
        rst = 1'b1;
        repeat (5) tick();

        // 1: valid start, nominal bytes
        sb.push_back({1'b0, F_1});
        host_start(300);
        wait_drain("t1_frame", 10000);

        // 2: start pulse too short -> silence
        d0   = drive_cnt;
        seen = 1'b0;
        host_start(100);
        repeat (300) begin
            tick();
            if (busy) seen = 1'b1;
        end
        check("t2_busy_never", {63'd0, seen}, 64'd0);
        check("t2_no_drive", drive_cnt - d0, 0);

        // 3: corrupted checksum
        corrupt_chk = 1'b1;
        sb.push_back({1'b0, F_C});
        host_start(300);
        wait_drain("t3_frame", 10000);
        corrupt_chk = 1'b0;

        // 4: host contention in bit 10 released phase
        sb.push_back({1'b1, 40'd0});
        host_start(300);
        wait_busy("t4_busy", 500);
        wait_nlow("t4_reach_bit10", 12, 5000);
        repeat (10) tick();
        host_low = 1'b1;
        repeat (20) tick();
        host_low = 1'b0;
        repeat (10) tick();
        check("t4_busy_after_err", {63'd0, busy}, 64'd0);
        check("t4_dth_released", {63'd0, DTH}, 64'd1);
        wait_drain("t4_err", 1000);
        sb.push_back({1'b0, F_1});
        host_start(300);
        wait_drain("t4_next_frame", 10000);

        // 5: reset in the middle of bit 20
        sb.push_back({1'b0, F_1});
        host_start(300);
        wait_busy("t5_busy", 500);
        wait_nlow("t5_reach_bit19", 21, 5000);
        n = 0;
        while (DTH !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("t5_in_bit20_low", {63'd0, DTH}, 64'd0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("t5_dth_released", {63'd0, DTH}, 64'd1);
        check("t5_busy_cleared", {63'd0, busy}, 64'd0);
        void'(sb.pop_back());
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (frame_done) seen = 1'b1;
        end
        check("t5_no_frame_done", {63'd0, seen}, 64'd0);
        rst = 1'b1;
        repeat (5) tick();
        sb.push_back({1'b0, F_1});
        host_start(300);
        wait_drain("t5_post_reset_frame", 10000);

        // 6: inputs change mid-frame, next frame picks them up
        sb.push_back({1'b0, F_1});
        host_start(300);
        wait_busy("t6_busy", 500);
        repeat (500) tick();
        hum_int = 8'h55;
        wait_drain("t6_frame1", 10000);
        sb.push_back({1'b0, F_6});
        host_start(300);
        wait_drain("t6_frame2", 10000);

        check("sb_empty_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
